floo_route_decode_unit: RTL and testbench

- Per-input-port route decoder for the XY-mesh router.
- Converts a flit's destination header into a one-hot (unicast) or multi-hot (multicast) output-port select vector.
- Unicast uses either an ID address-rule table or XY routing; multicast uses a destination-ID-plus-don't-care-mask scheme on the XY tree.
- Result is registered: one-cycle latency ahead of the switch allocator.

---
 rtl/floo_route_decode_unit_if.sv | 90 +++++++++
 rtl/floo_route_decode_unit.sv | 199 +++++++++++++++++++
 tb/tb_floo_route_decode_unit.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/floo_route_decode_unit_if.sv
// floo_route_decode_unit_if
// Header, routing-context and result signals of one route decoder.
// The slave modport faces the decoder and the master modport faces the driver.
// The default-port inputs exist only when ROUTE_DEFAULT_PORT_EN is defined.

interface floo_route_decode_unit_if #(
    parameter int unsigned NumRoutes    = 5,
    parameter int unsigned XWidth       = 3,
    parameter int unsigned YWidth       = 3,
    parameter int unsigned NumAddrRules = 4,
    parameter int unsigned IdWidth      = XWidth + YWidth,
    parameter int unsigned IdxWidth     = $clog2(NumRoutes)
);

    // Header and routing context presented with the flit
    logic                             valid_i;
    logic                             mcast_i;
    logic                             table_mode_i;
    logic [XWidth-1:0]                dst_x_i;
    logic [YWidth-1:0]                dst_y_i;
    logic [XWidth-1:0]                mask_x_i;
    logic [YWidth-1:0]                mask_y_i;
    logic [XWidth-1:0]                xy_x_i;
    logic [YWidth-1:0]                xy_y_i;
    logic [NumRoutes-1:0]             in_port_i;
    logic [NumAddrRules*IdxWidth-1:0] rule_idx_i;
    logic [NumAddrRules*IdWidth-1:0]  rule_start_i;
    logic [NumAddrRules*IdWidth-1:0]  rule_end_i;
`ifdef ROUTE_DEFAULT_PORT_EN
    logic [IdxWidth-1:0]              default_idx_i;
    logic                             en_default_i;
`endif

    // Registered decode result
    logic                             valid_o;
    logic [NumRoutes-1:0]             route_sel_o;
    logic                             dec_valid_o;
    logic                             dec_error_o;

    modport slave (
        output valid_o,
        output route_sel_o,
        output dec_valid_o,
        output dec_error_o,
        input  valid_i,
        input  mcast_i,
        input  table_mode_i,
        input  dst_x_i,
        input  dst_y_i,
        input  mask_x_i,
        input  mask_y_i,
        input  xy_x_i,
        input  xy_y_i,
        input  in_port_i,
        input  rule_idx_i,
        input  rule_start_i,
        input  rule_end_i
`ifdef ROUTE_DEFAULT_PORT_EN
        ,
        input  default_idx_i,
        input  en_default_i
`endif
    );

    modport master (
        input  valid_o,
        input  route_sel_o,
        input  dec_valid_o,
        input  dec_error_o,
        output valid_i,
        output mcast_i,
        output table_mode_i,
        output dst_x_i,
        output dst_y_i,
        output mask_x_i,
        output mask_y_i,
        output xy_x_i,
        output xy_y_i,
        output in_port_i,
        output rule_idx_i,
        output rule_start_i,
        output rule_end_i
`ifdef ROUTE_DEFAULT_PORT_EN
        ,
        output default_idx_i,
        output en_default_i
`endif
    );

endinterface

// File: rtl/floo_route_decode_unit.sv
// floo_route_decode_unit
// Per-input-port route decoder of the XY-mesh router. It turns a flit header
// into an output-port select vector: one-hot for unicast (XY routing or the
// ID address-rule table) and multi-hot for multicast (destination plus
// don't-care mask, routed on the XY tree). The result is registered so it is
// ready one cycle later for the switch allocator.
// Port order: 0 Eject, 1 South, 2 West, 3 North, 4 East.
// Optional feature: define ROUTE_DEFAULT_PORT_EN to add a default port that
// is used on a table miss when en_default_i is set.

module floo_route_decode_unit #(
    parameter int unsigned NumRoutes    = 5,
    parameter int unsigned XWidth       = 3,
    parameter int unsigned YWidth       = 3,
    parameter int unsigned NumAddrRules = 4,
    parameter int unsigned IdWidth      = XWidth + YWidth,
    parameter int unsigned IdxWidth     = $clog2(NumRoutes)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    floo_route_decode_unit_if.slave       bus
);

    localparam int unsigned PortEject = 0;
    localparam int unsigned PortSouth = 1;
    localparam int unsigned PortWest  = 2;
    localparam int unsigned PortNorth = 3;
    localparam int unsigned PortEast  = 4;

    // Turns a port index into a one-hot select; indices past the last port give zero
    function automatic logic [NumRoutes-1:0] portOneHot(input logic [IdxWidth-1:0] idx);
        logic [NumRoutes-1:0] sel;
        sel = '0;
        for (int p = 0; p < NumRoutes; p++) begin
            sel[p] = (idx == IdxWidth'(p));
        end
        return sel;
    endfunction

    // Unicast XY routing results
    logic [NumRoutes-1:0]    w_xySel;

    // ID-table lookup results
    logic [IdWidth-1:0]      w_dstId;
    logic [NumAddrRules-1:0] w_ruleMatch;
    logic                    w_tblHit;
    logic [IdxWidth-1:0]     w_hitIdx;
    logic                    w_idxLegal;
    logic [NumRoutes-1:0]    w_tblSel;
    logic                    w_tblValid;
    logic                    w_tblError;

    // Multicast tree results
    logic                    w_xHit;
    logic                    w_yHit;
    logic                    w_eastAny;
    logic                    w_westAny;
    logic                    w_northAny;
    logic                    w_southAny;
    logic                    w_fromNs;
    logic [NumRoutes-1:0]    w_mcSel;

    // Selected next-state values
    logic [NumRoutes-1:0]    w_nextSel;
    logic                    w_nextDecValid;
    logic                    w_nextDecError;

    // Output registers
    logic                    r_valid;
    logic [NumRoutes-1:0]    r_routeSel;
    logic                    r_decValid;
    logic                    r_decError;

    // Dimension-ordered routing: resolve X first, then Y, eject when both agree
    always_comb begin
        w_xySel = '0;
        if ((bus.dst_x_i == bus.xy_x_i) && (bus.dst_y_i == bus.xy_y_i)) begin
            w_xySel[PortEject] = 1'b1;
        end else if (bus.dst_x_i == bus.xy_x_i) begin
            if (bus.dst_y_i < bus.xy_y_i) begin
                w_xySel[PortSouth] = 1'b1;
            end else begin
                w_xySel[PortNorth] = 1'b1;
            end
        end else if (bus.dst_x_i < bus.xy_x_i) begin
            w_xySel[PortWest] = 1'b1;
        end else begin
            w_xySel[PortEast] = 1'b1;
        end
    end

    // The destination ID packs Y in the upper bits
    assign w_dstId = {bus.dst_y_i, bus.dst_x_i};

    // Each rule covers the half-open ID range [start, end)
    for (genvar g = 0; g < NumAddrRules; g++) begin : gen_rule_match
        assign w_ruleMatch[g] =
            (bus.rule_start_i[g*IdWidth +: IdWidth] <= w_dstId) &&
            (w_dstId < bus.rule_end_i[g*IdWidth +: IdWidth]);
    end

    // Scan rules in ascending order so the highest matching rule is the one kept
    always_comb begin
        w_tblHit = 1'b0;
        w_hitIdx = '0;
        for (int r = 0; r < NumAddrRules; r++) begin
            if (w_ruleMatch[r]) begin
                w_tblHit = 1'b1;
                w_hitIdx = bus.rule_idx_i[r*IdxWidth +: IdxWidth];
            end
        end
    end

    // Compare with one spare bit so a port count that fills the index field still works
    assign w_idxLegal = ({1'b0, w_hitIdx} < (IdxWidth + 1)'(NumRoutes));

    // Table outcome: a legal hit routes and flags valid, anything else is an error
    always_comb begin
        w_tblSel   = '0;
        w_tblValid = 1'b0;
        w_tblError = 1'b0;
        if (w_tblHit && w_idxLegal) begin
            w_tblSel   = portOneHot(w_hitIdx);
            w_tblValid = 1'b1;
        end else begin
`ifdef ROUTE_DEFAULT_PORT_EN
            if (!w_tblHit && bus.en_default_i) begin
                w_tblSel = portOneHot(bus.default_idx_i);
            end else begin
                w_tblError = 1'b1;
            end
`else
            w_tblError = 1'b1;
`endif
        end
    end

    // The mask widens the destination to a set; this router is in it when all
    // cared-about bits agree, and the set extends past us when its extreme
    // member (all masked bits high or low) lies beyond our coordinate
    assign w_xHit     = ((bus.xy_x_i ^ bus.dst_x_i) & ~bus.mask_x_i) == '0;
    assign w_yHit     = ((bus.xy_y_i ^ bus.dst_y_i) & ~bus.mask_y_i) == '0;
    assign w_eastAny  = (bus.dst_x_i | bus.mask_x_i) > bus.xy_x_i;
    assign w_westAny  = (bus.dst_x_i & ~bus.mask_x_i) < bus.xy_x_i;
    assign w_northAny = (bus.dst_y_i | bus.mask_y_i) > bus.xy_y_i;
    assign w_southAny = (bus.dst_y_i & ~bus.mask_y_i) < bus.xy_y_i;
    assign w_fromNs   = bus.in_port_i[PortSouth] | bus.in_port_i[PortNorth];

    // Tree fan-out: never back out the input port, and once travelling in Y never turn to X
    always_comb begin
        w_mcSel            = '0;
        w_mcSel[PortEject] = w_xHit & w_yHit;
        w_mcSel[PortSouth] = w_xHit & w_southAny & ~bus.in_port_i[PortSouth];
        w_mcSel[PortWest]  = w_westAny & ~bus.in_port_i[PortWest] & ~w_fromNs;
        w_mcSel[PortNorth] = w_xHit & w_northAny & ~bus.in_port_i[PortNorth];
        w_mcSel[PortEast]  = w_eastAny & ~bus.in_port_i[PortEast] & ~w_fromNs;
    end

    // Multicast overrides the table-mode bit; status flags only report table lookups
    always_comb begin
        w_nextSel      = w_xySel;
        w_nextDecValid = 1'b0;
        w_nextDecError = 1'b0;
        if (bus.mcast_i) begin
            w_nextSel = w_mcSel;
        end else if (bus.table_mode_i) begin
            w_nextSel      = w_tblSel;
            w_nextDecValid = w_tblValid;
            w_nextDecError = w_tblError;
        end
    end

    // Register the decision; the route and flags only move when a header is present
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_routeSel <= '0;
            r_decValid <= 1'b0;
            r_decError <= 1'b0;
        end else begin
            r_valid <= bus.valid_i;
            if (bus.valid_i) begin
                r_routeSel <= w_nextSel;
                r_decValid <= w_nextDecValid;
                r_decError <= w_nextDecError;
            end
        end
    end

    assign bus.valid_o     = r_valid;
    assign bus.route_sel_o = r_routeSel;
    assign bus.dec_valid_o = r_decValid;
    assign bus.dec_error_o = r_decError;

    // A multicast header must name exactly one arrival port for suppression to make sense
    assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.valid_i && bus.mcast_i) |-> $onehot(bus.in_port_i));

endmodule

// File: tb/tb_floo_route_decode_unit.sv
// tb_floo_route_decode_unit
// Drives directed and random headers into floo_route_decode_unit, pushes the
// reference-model result for every valid header into a queue, and lets an
// independent monitor pop and compare whenever valid_o is seen. Idle cycles
// are checked for holding the last result.

module tb_floo_route_decode_unit;

    localparam int NumRoutes    = 5;
    localparam int XWidth       = 3;
    localparam int YWidth       = 3;
    localparam int NumAddrRules = 4;
    localparam int IdWidth      = XWidth + YWidth;
    localparam int IdxWidth     = $clog2(NumRoutes);

    typedef struct {
        bit valid;
        bit mcast;
        bit tableMode;
        int curX;
        int curY;
        int dstX;
        int dstY;
        int maskX;
        int maskY;
        int inPort;
        int ruleIdx[NumAddrRules];
        int ruleStart[NumAddrRules];
        int ruleEnd[NumAddrRules];
    } stim_t;

    typedef struct packed {
        logic [NumRoutes-1:0] sel;
        logic                 decValid;
        logic                 decError;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    exp_t lastExp = '0;
    bit   monitorEn = 1'b0;

    floo_route_decode_unit_if #(
        .NumRoutes(NumRoutes), .XWidth(XWidth), .YWidth(YWidth),
        .NumAddrRules(NumAddrRules)
    ) bus ();

    floo_route_decode_unit #(
        .NumRoutes(NumRoutes), .XWidth(XWidth), .YWidth(YWidth),
        .NumAddrRules(NumAddrRules)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference model: expected decode of one header straight from the routing rules
    function automatic exp_t modelDecode(input stim_t s);
        exp_t e;
        e = '0;
        if (s.mcast) begin
            bit xHit = 0, yHit = 0, eastAny = 0, westAny = 0, northAny = 0, southAny = 0;
            bit fromNs;
            // Enumerate every column/row the masked destination covers
            for (int x = 0; x < (1 << XWidth); x++) begin
                if (((x ^ s.dstX) & ~s.maskX & ((1 << XWidth) - 1)) == 0) begin
                    if (x == s.curX) xHit = 1;
                    if (x > s.curX) eastAny = 1;
                    if (x < s.curX) westAny = 1;
                end
            end
            for (int y = 0; y < (1 << YWidth); y++) begin
                if (((y ^ s.dstY) & ~s.maskY & ((1 << YWidth) - 1)) == 0) begin
                    if (y == s.curY) yHit = 1;
                    if (y > s.curY) northAny = 1;
                    if (y < s.curY) southAny = 1;
                end
            end
            fromNs = (s.inPort == 2) || (s.inPort == 8);
            e.sel[0] = xHit && yHit;
            e.sel[1] = xHit && southAny && (s.inPort != 2);
            e.sel[2] = westAny && (s.inPort != 4) && !fromNs;
            e.sel[3] = xHit && northAny && (s.inPort != 8);
            e.sel[4] = eastAny && (s.inPort != 16) && !fromNs;
        end else if (s.tableMode) begin
            int id;
            int hitRule;
            id = s.dstY * (1 << XWidth) + s.dstX;
            hitRule = -1;
            for (int r = NumAddrRules - 1; r >= 0; r--) begin
                if (hitRule < 0 && id >= s.ruleStart[r] && id < s.ruleEnd[r]) hitRule = r;
            end
            if (hitRule >= 0 && s.ruleIdx[hitRule] < NumRoutes) begin
                e.sel[s.ruleIdx[hitRule]] = 1'b1;
                e.decValid = 1'b1;
            end else begin
                e.decError = 1'b1;
            end
        end else begin
            if (s.dstX == s.curX && s.dstY == s.curY) e.sel[0] = 1'b1;
            else if (s.dstX == s.curX) e.sel[(s.dstY < s.curY) ? 1 : 3] = 1'b1;
            else e.sel[(s.dstX < s.curX) ? 2 : 4] = 1'b1;
        end
        return e;
    endfunction

    // One comparison; every mismatch prints a single FAIL line
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one header on the falling edge and queue its expected result if valid
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        bus.valid_i      = s.valid;
        bus.mcast_i      = s.mcast;
        bus.table_mode_i = s.tableMode;
        bus.xy_x_i       = XWidth'(s.curX);
        bus.xy_y_i       = YWidth'(s.curY);
        bus.dst_x_i      = XWidth'(s.dstX);
        bus.dst_y_i      = YWidth'(s.dstY);
        bus.mask_x_i     = XWidth'(s.maskX);
        bus.mask_y_i     = YWidth'(s.maskY);
        bus.in_port_i    = NumRoutes'(s.inPort);
        for (int r = 0; r < NumAddrRules; r++) begin
            bus.rule_idx_i[r*IdxWidth +: IdxWidth]  = IdxWidth'(s.ruleIdx[r]);
            bus.rule_start_i[r*IdWidth +: IdWidth]  = IdWidth'(s.ruleStart[r]);
            bus.rule_end_i[r*IdWidth +: IdWidth]    = IdWidth'(s.ruleEnd[r]);
        end
        if (s.valid) expQ.push_back(modelDecode(s));
    endtask

    // Reset with a valid header present; reset must win and clear everything
    task automatic doReset();
        @(negedge clk);
        monitorEn   = 1'b0;
        rst         = 1'b1;
        bus.valid_i = 1'b1;
        @(negedge clk);
        checkOutput("resetValid", 32'(bus.valid_o), 32'd0);
        checkOutput("resetSel", 32'(bus.route_sel_o), 32'd0);
        checkOutput("resetDecValid", 32'(bus.dec_valid_o), 32'd0);
        checkOutput("resetDecError", 32'(bus.dec_error_o), 32'd0);
        lastExp     = '0;
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        monitorEn   = 1'b1;
    endtask

    // Wait for all queued results to appear, bounded
    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drainQueueEmpty", 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    function automatic stim_t baseStim();
        stim_t s;
        s.valid = 1; s.mcast = 0; s.tableMode = 0;
        s.curX = 2; s.curY = 2; s.dstX = 2; s.dstY = 2;
        s.maskX = 0; s.maskY = 0; s.inPort = 1;
        for (int r = 0; r < NumAddrRules; r++) begin
            s.ruleIdx[r] = 0; s.ruleStart[r] = 0; s.ruleEnd[r] = 0;
        end
        return s;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s = baseStim();
        s.valid = 0;
        s.dstX = int'($urandom_range(0, 7));
        s.mcast = ($urandom_range(0, 1) == 1);
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s = baseStim();
        s.valid     = ($urandom_range(0, 3) != 0);
        s.mcast     = ($urandom_range(0, 2) == 0);
        s.tableMode = ($urandom_range(0, 1) == 1);
        s.curX  = int'($urandom_range(0, 7));
        s.curY  = int'($urandom_range(0, 7));
        s.dstX  = int'($urandom_range(0, 7));
        s.dstY  = int'($urandom_range(0, 7));
        s.maskX = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 7));
        s.maskY = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 7));
        s.inPort = 1 << $urandom_range(0, NumRoutes - 1);
        for (int r = 0; r < NumAddrRules; r++) begin
            s.ruleIdx[r]   = int'($urandom_range(0, 6));
            s.ruleStart[r] = int'($urandom_range(0, 63));
            s.ruleEnd[r]   = s.ruleStart[r] + int'($urandom_range(0, 40));
            if (s.ruleEnd[r] > 63) s.ruleEnd[r] = 63;
        end
        return s;
    endfunction

    // Monitor: pop and compare on every valid_o, otherwise the result must hold
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (monitorEn) begin
                if (bus.valid_o === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedValid", 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("routeSel", 32'(bus.route_sel_o), 32'(e.sel));
                        checkOutput("decValid", 32'(bus.dec_valid_o), 32'(e.decValid));
                        checkOutput("decError", 32'(bus.dec_error_o), 32'(e.decError));
                        lastExp = e;
                    end
                end else if (bus.valid_o === 1'b0) begin
                    checkOutput("holdSel", 32'(bus.route_sel_o), 32'(lastExp.sel));
                    checkOutput("holdDecValid", 32'(bus.dec_valid_o), 32'(lastExp.decValid));
                    checkOutput("holdDecError", 32'(bus.dec_error_o), 32'(lastExp.decError));
                end else begin
                    checkOutput("validKnown", 32'(bus.valid_o), 32'd0);
                end
            end
        end
    end

    // Global time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        stim_t s;
        bus.valid_i = 1'b0;
        bus.mcast_i = 1'b0;
        bus.table_mode_i = 1'b0;
        bus.xy_x_i = '0; bus.xy_y_i = '0;
        bus.dst_x_i = '0; bus.dst_y_i = '0;
        bus.mask_x_i = '0; bus.mask_y_i = '0;
        bus.in_port_i = 5'b00001;
        bus.rule_idx_i = '0; bus.rule_start_i = '0; bus.rule_end_i = '0;
`ifdef ROUTE_DEFAULT_PORT_EN
        bus.default_idx_i = '0;
        bus.en_default_i  = 1'b0;
`endif

        doReset();

        // Unicast XY: eject, east, south
        s = baseStim();
        applyStimulus(s);
        s.dstX = 5; s.dstY = 1;
        applyStimulus(s);
        s.dstX = 2; s.dstY = 0;
        applyStimulus(s);

        // Multicast broadcast from local, from west, from south
        s = baseStim();
        s.mcast = 1; s.dstX = 0; s.dstY = 0; s.maskX = 7; s.maskY = 7;
        s.inPort = 5'b00001;
        applyStimulus(s);
        s.inPort = 5'b00100;
        applyStimulus(s);
        s.inPort = 5'b00010;
        applyStimulus(s);

        // Zero mask behaves like XY, still suppressing the input port
        s.maskX = 0; s.maskY = 0; s.dstX = 6; s.dstY = 2; s.inPort = 5'b10000;
        applyStimulus(s);

        // Table mode: overlapping hit, miss, illegal index
        s = baseStim();
        s.tableMode = 1;
        s.ruleIdx[0] = 1; s.ruleStart[0] = 0; s.ruleEnd[0] = 8;
        s.ruleIdx[1] = 3; s.ruleStart[1] = 4; s.ruleEnd[1] = 16;
        s.dstY = 0; s.dstX = 5;
        applyStimulus(s);
        s.dstY = 5; s.dstX = 0;
        applyStimulus(s);
        s.ruleIdx[2] = 6; s.ruleStart[2] = 30; s.ruleEnd[2] = 35;
        s.dstY = 4; s.dstX = 0;
        applyStimulus(s);
        s.dstY = 0; s.dstX = 5;
        applyStimulus(s);

        // Idle cycles: result must hold while valid_o drops
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        drain();

        // Reset wins over a present header
        doReset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(randStim());
        end
        applyStimulus(idleStim());
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
